psram_arbiter: RTL
==================

# psram_arbiter

Two-port arbiter/sequencer sitting between two bus masters (port 0: DCJ11 CPU bridge, port 1: video/DMA fetcher) and channel 0 of the Gowin PSRAM HS memory interface. It grants one requester at a time, issues the single-cycle `cmd_en` command, drives the write beat and mask, captures the first read beat, and enforces the minimum command spacing the PSRAM IP requires. All logic runs in the PSRAM user clock domain. Requesters must already be synchronised to that domain.

## Interface
- `CMD_GAP`, 14: minimum `clk_out` cycles from one `cmd_en` pulse to the next (≥4).
- `BURST_BEATS`, 4: `rd_data_valid` beats per read burst; also write beats per command.
- `RD_TIMEOUT`, 64: cycles to wait for the first read beat before aborting.
- `FIXED_PRI`, 0: 1 = port 0 always wins; 0 = round-robin.

Ports:
- `clk_out`  in  1  PSRAM user clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `init_calib`  in  1  PSRAM calibration done; no grant while low.
- `req[1:0]`  in  2  per-port request level.
- `we[1:0]`  in  2  per-port 1 = write, 0 = read.
- `addr0`, `addr1`  in  21 each  word address (32-bit word granularity).
- `wdata0`, `wdata1`  in  32 each  write data.
- `wmask0`, `wmask1`  in  4 each  byte mask, 1 = byte NOT written.
- `ack[1:0]`  out  2  one-cycle completion pulse per port.
- `rdata`  out  32  read data, valid while the matching `ack` is high for a read.
- `rd_err`  out  1  pulses with `ack` when a read timed out (`rdata` = 0).
- `busy`  out  1  high in any state except IDLE.
- `cmd`, `cmd_en`  out  1 each  PSRAM command (1 = write) and command strobe.
- `mem_addr`  out  21  PSRAM address.
- `wr_data`  out  32  PSRAM write data.
- `data_mask`  out  4  PSRAM byte mask.
- `rd_data`  in  32  PSRAM read data.
- `rd_data_valid`  in  1  PSRAM read beat valid.

## Operation
- Request rule: the requester raises `req[i]` with `we`/addr/data/mask stable and holds them until it sees `ack[i]`. It drops `req[i]` the cycle after `ack[i]` at the latest. A request still high after its ack is treated as a new request.
- Arbitration in IDLE with `init_calib`=1 and the gap counter expired:
  - One port requesting: that port wins.
  - Both requesting, `FIXED_PRI`=1: port 0 wins.
  - Both requesting, `FIXED_PRI`=0: the port not granted last wins. The last-grant pointer resets to port 1, so port 0 wins first.
- States:
  - IDLE → WR on a write grant. That cycle latches `cmd`=1, `cmd_en`=1, `mem_addr`, `wr_data`=wdata, `data_mask`=wmask.
  - IDLE → RD on a read grant. That cycle latches `cmd`=0, `cmd_en`=1, `mem_addr`.
  - WR: `cmd_en`=0 and `data_mask`=4'hF for the remaining `BURST_BEATS`−1 beats. `ack` pulses on the first WR cycle. Then → GAP.
  - RD: `cmd_en`=0. On the first `rd_data_valid`, `rdata`←`rd_data` and `ack` pulses the same cycle.
    - Further beats are counted and discarded.
    - After `BURST_BEATS` beats → GAP.
    - If no beat arrives within `RD_TIMEOUT` cycles of `cmd_en`: `ack`+`rd_err` pulse with `rdata`=0, then → GAP.
    - Late beats from a timed-out burst are ignored.
  - GAP: wait until `CMD_GAP` cycles have elapsed since `cmd_en`, then → IDLE.
- `rd_data_valid` seen in IDLE or WR is ignored.
- `init_calib` falling mid-transaction: the current transaction still completes. No new grant is issued until `init_calib` returns high.

## Timing
- Reset values: state IDLE, `ack`=0, `rd_err`=0, `busy`=0, `cmd`=0, `cmd_en`=0, `mem_addr`=0, `wr_data`=0, `data_mask`=4'hF, `rdata`=0, last-grant pointer = port 1, all counters 0.
- All outputs are registered.
- Write:
  - `req` high at cycle N (IDLE, gap expired) → `cmd_en` high at N+1, `ack` at N+2.
  - The next `cmd_en` comes no earlier than N+1+`CMD_GAP`.
- Read:
  - `cmd_en` at N+1.
  - `ack` is in the cycle after the first `rd_data_valid` beat; `rdata` is registered from that beat.
- `cmd_en` is exactly one cycle wide. Never two pulses closer than `CMD_GAP`.
- The gap counter is an 8-bit saturating counter, cleared on `cmd_en`. The timeout counter is 8-bit. Parameters > 255 are illegal.
- Async `rst` mid-transaction forces the reset values immediately. Any in-flight PSRAM beats after reset release are ignored, because the arbiter is in IDLE.

## Test plan
- Single write, port 0, addr 21'h00123, wdata 32'hDEADBEEF, wmask 4'h3:
  - one `cmd_en` with `cmd`=1 and those values;
  - `data_mask`=4'hF on the next 3 cycles;
  - `ack[0]` pulse 1 cycle after `cmd_en`.
- Read, port 1, addr 21'h1FFFFF:
  - model returns 32'hCAFEF00D on beat 1 then 3 other beats, 5 cycles after `cmd_en`;
  - `ack[1]` with `rdata`=32'hCAFEF00D;
  - the other beats do not change `rdata`.
- Both ports requesting continuously, `FIXED_PRI`=0:
  - grants alternate 0,1,0,1;
  - every `cmd_en` pair is ≥14 cycles apart;
  - with `FIXED_PRI`=1, only port 0 is served while its `req` stays high.
- Read with no `rd_data_valid`:
  - `ack`+`rd_err` exactly 64 cycles after `cmd_en`, `rdata`=0;
  - a late burst afterwards does not produce `ack`.
- `init_calib`=0 with `req`=2'b11: no `cmd_en` and no `ack`. Raise `init_calib`: `cmd_en` within 2 cycles.
- Assert `rst` during RD:
  - all outputs return to reset values in the same cycle;
  - after release, the next `req` is served normally.

Source files
------------

// File: rtl/psram_arbiter.sv
`default_nettype none
// ============================================================================
// psram_arbiter -- two-port arbiter/sequencer for Gowin PSRAM HS channel 0
// Rev 1.0 -- initial release
// ============================================================================
module psram_arbiter #(
  parameter int CMD_GAP     = 14,
  parameter int BURST_BEATS = 4,
  parameter int RD_TIMEOUT  = 64,
  parameter bit FIXED_PRI   = 1'b0
) (
  input  logic        clk_out,
  input  logic        rst,
  input  logic        init_calib,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [20:0] addr0,
  input  logic [20:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  wmask0,
  input  logic [3:0]  wmask1,
  output logic [1:0]  ack,
  output logic [31:0] rdata,
  output logic        rd_err,
  output logic        busy,
  output logic        cmd,
  output logic        cmd_en,
  output logic [20:0] mem_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  data_mask,
  input  logic [31:0] rd_data,
  input  logic        rd_data_valid
);

  localparam logic [7:0] GAP_LAST  = 8'(CMD_GAP - 1);
  localparam logic [7:0] GAP_EXIT  = 8'(CMD_GAP - 2);
  localparam logic [7:0] BEAT_LAST = 8'(BURST_BEATS - 1);
  localparam logic [7:0] TO_LAST   = 8'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, GAP = 2'd3} state_t;

  state_t      state;
  logic        port;
  logic        last;
  logic        acked;
  logic [7:0]  gap_cnt;
  logic [7:0]  to_cnt;
  logic [7:0]  beat_cnt;

  logic        win;
  logic        grant;
  logic        sel_we;
  logic [20:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wmask;

  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = FIXED_PRI ? 1'b0 : ~last;
    else              win = req[1];
  end

  assign grant     = (state == IDLE) && init_calib && (gap_cnt >= GAP_LAST) && (req != 2'b00);
  assign sel_we    = win ? we[1]  : we[0];
  assign sel_addr  = win ? addr1  : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;
  assign sel_wmask = win ? wmask1 : wmask0;

  always_ff @(posedge clk_out or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= 2'b00;
      rd_err    <= 1'b0;
      busy      <= 1'b0;
      cmd       <= 1'b0;
      cmd_en    <= 1'b0;
      mem_addr  <= 21'h0;
      wr_data   <= 32'h0;
      data_mask <= 4'hF;
      rdata     <= 32'h0;
      port      <= 1'b0;
      last      <= 1'b1;
      acked     <= 1'b0;
      gap_cnt   <= 8'h0;
      to_cnt    <= 8'h0;
      beat_cnt  <= 8'h0;
    end else begin
      ack    <= 2'b00;
      rd_err <= 1'b0;
      cmd_en <= 1'b0;
      if (gap_cnt != 8'hFF) gap_cnt <= gap_cnt + 8'd1;

      case (state)
        IDLE: begin
          if (grant) begin
            port     <= win;
            last     <= win;
            cmd      <= sel_we;
            cmd_en   <= 1'b1;
            mem_addr <= sel_addr;
            busy     <= 1'b1;
            acked    <= 1'b0;
            gap_cnt  <= 8'h0;
            to_cnt   <= 8'h0;
            beat_cnt <= 8'h0;
            if (sel_we) begin
              wr_data   <= sel_wdata;
              data_mask <= sel_wmask;
              state     <= WR;
            end else begin
              state <= RD;
            end
          end
        end

        WR: begin
          data_mask <= 4'hF;
          if (beat_cnt == 8'h0) ack <= port ? 2'b10 : 2'b01;
          if (beat_cnt == BEAT_LAST) state    <= GAP;
          else                       beat_cnt <= beat_cnt + 8'd1;
        end

        RD: begin
          // the timeout keeps running after the first beat so a truncated burst cannot hang RD
          if (to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
          if (rd_data_valid) begin
            if (!acked) begin
              rdata <= rd_data;
              ack   <= port ? 2'b10 : 2'b01;
              acked <= 1'b1;
            end
            if (beat_cnt == BEAT_LAST) state    <= GAP;
            else                       beat_cnt <= beat_cnt + 8'd1;
          end else if (to_cnt >= TO_LAST) begin
            if (!acked) begin
              rdata  <= 32'h0;
              rd_err <= 1'b1;
              ack    <= port ? 2'b10 : 2'b01;
            end
            state <= GAP;
          end
        end

        GAP: begin
          // leave one cycle early so IDLE coincides with the first legal grant cycle
          if (gap_cnt >= GAP_EXIT) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
